// File: rtl/multicycle_alu.sv
// Handshaked ALU: simple ops complete in one cycle, MUL/DIVU/REMU iterate over WIDTH cycles.
// Result, zero and illegal are registered and held in DONE until the consumer takes them.
module multicycle_alu #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, divisor;

  logic             is_long, simple_ill;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] acc_nxt, rem_nxt, quo_nxt, iter_res;
  logic [WIDTH:0]   part;
  logic             no_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid  = (state == DONE);
    busy       = (state == BUSY);
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = is_long ? BUSY : DONE;
      BUSY: if (cnt == CNT_W'(1)) next_state = DONE;
      DONE: if (out_ready) next_state = in_valid ? (is_long ? BUSY : DONE) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle results; codes outside the known set take the illegal path.
  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    is_long    = 1'b0;
    case (control)
      OP_AND:  simple_res = a1 & a2;
      OP_OR:   simple_res = a1 | a2;
      OP_ADD:  simple_res = a1 + a2;
      OP_SUB:  simple_res = a1 - a2;
      OP_SLT:  simple_res = WIDTH'(a1 < a2);
      OP_MUL, OP_DIVU, OP_REMU: is_long = 1'b1;
      default: simple_ill = 1'b1;
    endcase
  end

  // One shift-add step and one restoring-division step per BUSY cycle.
  always_comb begin
    acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    part      = {rem, quo[WIDTH-1]};
    no_borrow = (part >= {1'b0, divisor});
    rem_nxt   = no_borrow ? (part[WIDTH-1:0] - divisor) : part[WIDTH-1:0];
    quo_nxt   = {quo[WIDTH-2:0], no_borrow};
    case (op)
      OP_MUL:  iter_res = acc_nxt;
      OP_DIVU: iter_res = quo_nxt;
      default: iter_res = rem_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op      <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (in_valid && in_ready) begin
      op      <= control;
      cnt     <= is_long ? CNT_W'(WIDTH) : '0;
      acc     <= '0;
      mcand   <= a1;
      mplier  <= a2;
      rem     <= '0;
      quo     <= a1;
      divisor <= a2;
      if (!is_long) begin
        result  <= simple_res;
        zero    <= !simple_ill && (simple_res == '0);
        illegal <= simple_ill;
      end
    end else if (state == BUSY) begin
      cnt    <= cnt - CNT_W'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      if (cnt == CNT_W'(1)) begin
        result  <= iter_res;
        zero    <= (iter_res == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule
